// File: rtl/motoro3_pwm_multi.sv
// motoro3_pwm_multi: N-channel complementary PWM with on-time carry, dead time,
// edge/centre alignment and per-period on-time measurement. State moves on negedge clk.
// Ports: clk, nRst (async low), pwmActive, alignMode, periodLen, minOn, deadTime,
//   dutyIn/dutyValid/dutyReady (duty handshake), periodStart, pwmH/pwmL (gates), onReal.
module motoro3_pwm_multi #(
  parameter int CH  = 3,
  parameter int CW  = 12,
  parameter int DW  = 16,
  parameter int DTW = 6
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            pwmActive,
  input  logic            alignMode,
  input  logic [CW-1:0]   periodLen,
  input  logic [DW-1:0]   minOn,
  input  logic [DTW-1:0]  deadTime,
  input  logic [CH*DW-1:0] dutyIn,
  input  logic            dutyValid,
  output logic            dutyReady,
  output logic            periodStart,
  output logic [CH-1:0]   pwmH,
  output logic [CH-1:0]   pwmL,
  output logic [CH*DW-1:0] onReal
);

  localparam logic [DW+1:0] SAT = (DW+2)'({DW{1'b1}});

  logic            r_run, r_dir, r_mode, r_start, r_pendV;
  logic [CW-1:0]   r_cnt, r_P;
  logic [DW-1:0]   r_minOn;
  logic [DTW-1:0]  r_dt;
  logic [CH*DW-1:0] r_pend, r_act;

  logic            w_bnd, w_xfer, w_modeN, w_dirN;
  logic [CW-1:0]   w_P, w_PN, w_cntN, w_Pm1;
  logic [DW-1:0]   w_minN;
  logic [DTW-1:0]  w_dtN;
  logic [CH*DW-1:0] w_actN;

  assign w_Pm1  = r_P - CW'(1);
  // Inactive->active is handled as a boundary so the first period starts cleanly.
  assign w_bnd  = ~r_run | (r_mode ? (r_dir & (r_cnt == '0))
                                   : (r_cnt == w_Pm1));
  assign w_P    = (periodLen < CW'(2)) ? CW'(2) : periodLen;
  assign w_PN   = w_bnd ? w_P : r_P;
  assign w_modeN = w_bnd ? alignMode : r_mode;
  assign w_minN = w_bnd ? minOn : r_minOn;
  assign w_dtN  = w_bnd ? deadTime : r_dt;
  assign w_xfer = dutyValid & ~r_pendV;

  assign dutyReady   = ~r_pendV;
  assign periodStart = r_start;

  always_comb begin
    w_cntN = '0;
    w_dirN = 1'b0;
    if (w_bnd) begin
      w_cntN = '0;
    end else if (!r_mode) begin
      w_cntN = r_cnt + CW'(1);
    end else if (!r_dir) begin
      // Top of the up-leg repeats P-1 as the first down-leg tick.
      w_dirN = (r_cnt == w_Pm1);
      w_cntN = w_dirN ? r_cnt : r_cnt + CW'(1);
    end else begin
      w_dirN = 1'b1;
      w_cntN = r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_actN = r_act;
    if (w_bnd) begin
      if (w_xfer)       w_actN = dutyIn;
      else if (r_pendV) w_actN = r_pend;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      r_run <= 1'b0; r_dir <= 1'b0; r_mode <= 1'b0; r_start <= 1'b0;
      r_pendV <= 1'b0; r_cnt <= '0; r_P <= CW'(2); r_minOn <= '0;
      r_dt <= '0; r_pend <= '0; r_act <= '0;
    end else if (!pwmActive) begin
      r_run <= 1'b0; r_dir <= 1'b0; r_mode <= 1'b0; r_start <= 1'b0;
      r_pendV <= 1'b0; r_cnt <= '0; r_P <= CW'(2); r_minOn <= '0;
      r_dt <= '0; r_pend <= '0; r_act <= '0;
    end else begin
      r_run   <= 1'b1;
      r_cnt   <= w_cntN;
      r_dir   <= w_dirN;
      r_start <= w_bnd;
      r_P     <= w_PN;
      r_mode  <= w_modeN;
      r_minOn <= w_minN;
      r_dt    <= w_dtN;
      r_act   <= w_actN;
      if (w_bnd) begin
        r_pendV <= 1'b0;
      end else if (w_xfer) begin
        r_pendV <= 1'b1;
        r_pend  <= dutyIn;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0]  r_rem, r_on, r_hc, r_onReal;
    logic [DTW-1:0] r_age;
    logic           r_raw, r_H, r_L;

    logic [DW+1:0]  w_sum, w_pmax, w_len, w_rem0, w_rem1;
    logic [DW-1:0]  w_remS, w_onB, w_onN, w_remN, w_hcSum;
    logic [DTW-1:0] w_ageN;
    logic           w_short, w_rawN, w_edge, w_ok;

    assign w_sum   = (DW+2)'(w_actN[k*DW +: DW]) + (DW+2)'(r_rem);
    assign w_pmax  = w_modeN ? (DW+2)'({w_PN, 1'b0}) : (DW+2)'(w_PN);
    assign w_short = (w_sum != '0) & (w_sum < (DW+2)'(w_minN));
    assign w_len   = w_short ? '0 : ((w_sum < w_pmax) ? w_sum : w_pmax);
    assign w_rem0  = w_sum - w_len;
    // Centre mode can only place an even count; the odd tick is carried.
    assign w_rem1  = w_rem0 + (DW+2)'(w_modeN & w_len[0]);
    assign w_remS  = (w_rem1 > SAT) ? '1 : w_rem1[DW-1:0];
    assign w_onB   = w_modeN ? w_len[DW:1] : w_len[DW-1:0];
    assign w_onN   = w_bnd ? w_onB : r_on;
    assign w_remN  = w_bnd ? w_remS : r_rem;

    assign w_rawN = w_modeN
      ? ((DW+1)'(w_cntN) + (DW+1)'(w_onN) >= (DW+1)'(w_PN))
      : (DW'(w_cntN) < w_onN);

    // Leaving coast counts as an edge so the low side also waits dead time.
    assign w_edge  = (w_rawN != r_raw) | ~r_run;
    assign w_ageN  = w_edge ? '0 : ((&r_age) ? r_age : r_age + DTW'(1));
    assign w_ok    = (w_ageN >= w_dtN);
    assign w_hcSum = r_hc + DW'(r_raw);

    assign pwmH[k] = r_H;
    assign pwmL[k] = r_L;
    assign onReal[k*DW +: DW] = r_onReal;

    always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
        r_rem <= '0; r_on <= '0; r_hc <= '0; r_onReal <= '0;
        r_age <= '0; r_raw <= 1'b0; r_H <= 1'b0; r_L <= 1'b0;
      end else if (!pwmActive) begin
        r_rem <= '0; r_on <= '0; r_hc <= '0; r_onReal <= '0;
        r_age <= '0; r_raw <= 1'b0; r_H <= 1'b0; r_L <= 1'b0;
      end else begin
        r_rem <= w_remN;
        r_on  <= w_onN;
        r_raw <= w_rawN;
        r_age <= w_ageN;
        r_H   <= w_rawN & w_ok;
        r_L   <= ~w_rawN & w_ok;
        r_hc  <= w_bnd ? '0 : w_hcSum;
        if (w_bnd) r_onReal <= w_hcSum;
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// tb_motoro3_pwm_multi: directed + random checks of motoro3_pwm_multi
// against a period-level reference model.
module tb_motoro3_pwm_multi;
  localparam int CH = 3, CW = 12, DW = 16, DTW = 6;

  logic clk = 1'b0;
  logic nRst, pwmActive, alignMode, dutyValid;
  logic [CW-1:0] periodLen;
  logic [DW-1:0] minOn;
  logic [DTW-1:0] deadTime;
  logic [CH*DW-1:0] dutyIn;
  logic dutyReady, periodStart;
  logic [CH-1:0] pwmH, pwmL;
  logic [CH*DW-1:0] onReal;

  always #50 clk = ~clk;

  motoro3_pwm_multi #(.CH(CH), .CW(CW), .DW(DW), .DTW(DTW)) dut (
    .clk(clk), .nRst(nRst), .pwmActive(pwmActive), .alignMode(alignMode),
    .periodLen(periodLen), .minOn(minOn), .deadTime(deadTime),
    .dutyIn(dutyIn), .dutyValid(dutyValid), .dutyReady(dutyReady),
    .periodStart(periodStart), .pwmH(pwmH), .pwmL(pwmL), .onReal(onReal));

  int total = 0, bad = 0;

  bit m_run, m_pendV, m_start;
  int m_t, m_len, m_P, m_mode, m_minOn, m_dt;
  int m_pend[CH], m_act[CH], m_rem[CH], m_meas[CH], m_onReal[CH];
  bit m_raw[CH][8192];
  bit m_hist[CH][128];
  int g = 0, gs = 0;
  bit expH[CH], expL[CH];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_pendV = 0; m_start = 0; m_t = 0; m_len = 1;
    for (int k = 0; k < CH; k++) begin
      m_act[k] = 0; m_rem[k] = 0; m_meas[k] = 0; m_onReal[k] = 0;
      m_pend[k] = 0; expH[k] = 0; expL[k] = 0;
    end
  endtask

  // Shape one whole period from the duty/remainder rules.
  task automatic new_period();
    int sum, on, half, c;
    m_P = (periodLen < 2) ? 2 : int'(periodLen);
    m_mode = int'(alignMode);
    m_minOn = int'(minOn);
    m_dt = int'(deadTime);
    m_len = m_mode ? 2 * m_P : m_P;
    for (int k = 0; k < CH; k++) begin
      sum = m_act[k] + m_rem[k];
      if (sum > 0 && sum < m_minOn) begin
        on = 0; m_rem[k] = sum;
      end else begin
        on = (sum < m_len) ? sum : m_len;
        m_rem[k] = sum - on;
      end
      half = on / 2;
      if (m_mode != 0) m_rem[k] += on % 2;
      if (m_rem[k] > 65535) m_rem[k] = 65535;
      for (int t = 0; t < m_len; t++) begin
        if (m_mode == 0) m_raw[k][t] = (t < on);
        else begin
          c = (t < m_P) ? t : 2 * m_P - 1 - t;
          m_raw[k][t] = (c >= m_P - half);
        end
      end
    end
  endtask

  task automatic tick();
    bit bnd, xfer, r, ok;
    int idx;
    if (!pwmActive) model_clear();
    else begin
      bnd = !m_run || (m_t == m_len - 1);
      xfer = dutyValid && !m_pendV;
      if (m_run)
        for (int k = 0; k < CH; k++) m_meas[k] += int'(m_raw[k][m_t]);
      if (bnd) begin
        for (int k = 0; k < CH; k++) begin
          m_onReal[k] = m_meas[k]; m_meas[k] = 0;
        end
        if (xfer)
          for (int k = 0; k < CH; k++) m_act[k] = int'(dutyIn[k*DW +: DW]);
        else if (m_pendV)
          for (int k = 0; k < CH; k++) m_act[k] = m_pend[k];
        m_pendV = 0;
        if (!m_run) gs = g + 1;
        new_period();
        m_t = 0; m_run = 1; m_start = 1;
      end else begin
        m_t++; m_start = 0;
        if (xfer) begin
          for (int k = 0; k < CH; k++) m_pend[k] = int'(dutyIn[k*DW +: DW]);
          m_pendV = 1;
        end
      end
      g++;
      for (int k = 0; k < CH; k++) begin
        r = m_raw[k][m_t];
        m_hist[k][g % 128] = r;
        ok = 1;
        for (int j = 0; j <= m_dt; j++) begin
          idx = g - j;
          if (idx < gs || m_hist[k][idx % 128] != r) ok = 0;
        end
        expH[k] = r && ok;
        expL[k] = !r && ok;
      end
    end
    @(negedge clk);
    #10;
    chk("periodStart", periodStart, m_start);
    chk("dutyReady", dutyReady, !m_pendV);
    for (int k = 0; k < CH; k++) begin
      chk("pwmH", pwmH[k], expH[k]);
      chk("pwmL", pwmL[k], expL[k]);
      chk("onReal", onReal[k*DW +: DW], m_onReal[k]);
    end
  endtask

  task automatic setup(input int p, input bit md, input int mo, input int dt,
                       input int d0);
    pwmActive = 0;
    tick();
    periodLen = CW'(p); alignMode = md; minOn = DW'(mo); deadTime = DTW'(dt);
    dutyIn[0 +: DW] = DW'(d0);
    for (int k = 1; k < CH; k++) dutyIn[k*DW +: DW] = DW'($urandom_range(0, 60));
    dutyValid = 1;
    pwmActive = 1;
  endtask

  int cntH, cntL, cntR, h2, h3, l12, l13;
  int carryExp[6] = '{0, 0, 24, 0, 0, 24};

  initial begin
    nRst = 0; pwmActive = 0; alignMode = 0; dutyValid = 0;
    periodLen = '0; minOn = '0; deadTime = '0; dutyIn = '0;
    model_clear();
    #130;
    chk("rst_pwmH", pwmH, 0);
    chk("rst_pwmL", pwmL, 0);
    chk("rst_start", periodStart, 0);
    chk("rst_ready", dutyReady, 1);
    chk("rst_onReal", onReal, 0);
    nRst = 1;

    // Carry of sub-minimum on-time.
    setup(100, 0, 20, 0, 8);
    for (int p = 0; p < 6; p++) begin
      cntH = 0;
      for (int t = 0; t < 100; t++) begin
        tick(); cntH += int'(pwmH[0]);
      end
      chk("carry_len", cntH, carryExp[p]);
    end

    // Clamp and remainder saturation.
    setup(100, 0, 0, 0, 150);
    for (int p = 0; p < 3; p++) begin
      cntH = 0;
      for (int t = 0; t < 100; t++) begin
        tick(); cntH += int'(pwmH[0]);
      end
      chk("clamp_len", cntH, 100);
    end
    periodLen = CW'(1);
    dutyIn = {CH{16'hFFFF}};
    for (int t = 0; t < 12; t++) tick();
    dutyIn = '0;
    for (int t = 0; t < 20; t++) tick();

    // Dead time.
    setup(100, 0, 0, 3, 10);
    cntH = 0; cntL = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      cntH += int'(pwmH[0]); cntL += int'(pwmL[0]);
      if (t == 2) h2 = int'(pwmH[0]);
      if (t == 3) h3 = int'(pwmH[0]);
      if (t == 12) l12 = int'(pwmL[0]);
      if (t == 13) l13 = int'(pwmL[0]);
    end
    chk("dt_Hcount", cntH, 7);
    chk("dt_Lcount", cntL, 87);
    chk("dt_H2", h2, 0);
    chk("dt_H3", h3, 1);
    chk("dt_L12", l12, 0);
    chk("dt_L13", l13, 1);
    for (int t = 0; t < 100; t++) tick();

    // Centre aligned with odd duty.
    setup(50, 1, 0, 0, 21);
    for (int p = 0; p < 4; p++) begin
      cntH = 0;
      for (int t = 0; t < 100; t++) begin
        tick(); cntH += int'(pwmH[0]);
      end
      chk("centre_len", cntH, (p % 2 == 0) ? 20 : 22);
    end

    // Handshake: continuous valid, one acceptance per period.
    setup(20, 0, 0, 0, 5);
    for (int p = 0; p < 5; p++) begin
      cntR = 0;
      for (int t = 0; t < 20; t++) begin
        tick(); cntR += int'(dutyReady && dutyValid);
        for (int k = 0; k < CH; k++)
          dutyIn[k*DW +: DW] = DW'($urandom_range(0, 20));
      end
      chk("hs_accept", cntR, 1);
    end

    // Word accepted on the boundary tick shapes the next period.
    setup(20, 0, 0, 0, 3);
    tick();
    dutyValid = 0;
    cntH = int'(pwmH[0]);
    while (m_t != 19) begin
      tick(); cntH += int'(pwmH[0]);
    end
    chk("bypass_prev", cntH, 3);
    dutyIn[0 +: DW] = DW'(7);
    dutyValid = 1;
    cntH = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); cntH += int'(pwmH[0]);
      dutyValid = 0;
    end
    chk("bypass_next", cntH, 7);

    // Randomized configuration, duty and enable.
    for (int t = 0; t < 900; t++) begin
      periodLen = CW'($urandom_range(0, 40));
      alignMode = 1'($urandom_range(0, 1));
      minOn = DW'($urandom_range(0, 30));
      deadTime = DTW'($urandom_range(0, 7));
      dutyValid = 1'($urandom_range(0, 1));
      for (int k = 0; k < CH; k++)
        dutyIn[k*DW +: DW] = DW'($urandom_range(0, 90));
      pwmActive = ($urandom_range(0, 199) != 0);
      tick();
    end

    // Enable drop mid-period, re-enable, async reset mid-pulse.
    setup(100, 0, 0, 0, 50);
    tick();
    while (m_t != 37) tick();
    pwmActive = 0;
    tick();
    chk("drop_pwmH", pwmH, 0);
    chk("drop_pwmL", pwmL, 0);
    chk("drop_onReal", onReal, 0);
    pwmActive = 1;
    tick();
    chk("reen_start", periodStart, 1);
    while (m_t != 10) tick();
    nRst = 0;
    #1;
    chk("arst_pwmH", pwmH, 0);
    chk("arst_pwmL", pwmL, 0);
    chk("arst_onReal", onReal, 0);
    chk("arst_ready", dutyReady, 1);
    chk("arst_start", periodStart, 0);
    model_clear();
    #5;
    nRst = 1;
    for (int t = 0; t < 120; t++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
